// File: rtl/capture_seq.sv
// Capture sequencer: drives the shared RAMqueue write address/enable, arms the
// trigger once the pre-trigger window is full, and signals capture completion.
module capture_seq #(
  parameter int ENTRIES = 384,
  parameter int LOG2    = 9
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  input  logic            capture_done,
  input  logic            wrt_smpl,
  input  logic            triggered,
  input  logic [LOG2-1:0] trig_pos,
  output logic [LOG2-1:0] waddr,
  output logic            we,
  output logic            armed,
  output logic            capturing,
  output logic            set_capture_done
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  localparam logic [LOG2-1:0] LAST_ADDR = LOG2'(ENTRIES - 1);
  localparam logic [LOG2-1:0] ONE_A     = LOG2'(1);
  localparam logic [LOG2:0]   ENTRIES_W = (LOG2+1)'(ENTRIES);
  localparam logic [LOG2:0]   ONE_C     = (LOG2+1)'(1);

  state_t          r_state;
  logic [LOG2-1:0] r_waddr;
  logic [LOG2-1:0] r_trig_cnt;
  logic [LOG2:0]   r_smpl_cnt;
  logic            r_armed;

  logic [LOG2-1:0] w_tp_eff;
  logic [LOG2:0]   w_pre_req;
  logic [LOG2:0]   w_smpl_inc;
  logic            w_in_capture;
  logic            w_done_cond;
  logic            w_we;
  logic            w_set_done;

  // trig_pos is clamped so at least one pre-trigger sample is always kept
  always_comb begin
    w_tp_eff     = trig_pos;
    w_pre_req    = ENTRIES_W;
    w_smpl_inc   = r_smpl_cnt;
    w_in_capture = 1'b0;
    w_done_cond  = 1'b0;
    w_we         = 1'b0;
    w_set_done   = 1'b0;
    if ({1'b0, trig_pos} >= ENTRIES_W) begin
      w_tp_eff = LAST_ADDR;
    end else begin
      w_tp_eff = trig_pos;
    end
    w_pre_req = ENTRIES_W - {1'b0, w_tp_eff};
    if (r_smpl_cnt >= ENTRIES_W) begin
      w_smpl_inc = ENTRIES_W;
    end else begin
      w_smpl_inc = r_smpl_cnt + ONE_C;
    end
    w_in_capture = (r_state == ST_CAPTURE) && !rst;
    w_done_cond  = r_armed && triggered && (r_trig_cnt == w_tp_eff);
    w_set_done   = w_in_capture && run && w_done_cond;
    w_we         = w_in_capture && run && !w_done_cond && wrt_smpl;
  end

  assign waddr            = r_waddr;
  assign we               = w_we;
  assign armed            = r_armed;
  assign capturing        = (r_state == ST_CAPTURE);
  assign set_capture_done = w_set_done;

  // Sequencer state, address and sample counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_waddr    <= '0;
      r_smpl_cnt <= '0;
      r_trig_cnt <= '0;
      r_armed    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (run && !capture_done) begin
            r_state    <= ST_CAPTURE;
            r_waddr    <= '0;
            r_smpl_cnt <= '0;
            r_trig_cnt <= '0;
            r_armed    <= 1'b0;
          end
        end
        ST_CAPTURE: begin
          if (!run) begin
            r_state <= ST_IDLE;
            r_armed <= 1'b0;
          end else if (w_done_cond) begin
            r_state <= ST_DONE;
            r_armed <= 1'b0;
          end else if (wrt_smpl) begin
            r_waddr <= (r_waddr == LAST_ADDR) ? '0 : r_waddr + ONE_A;
            // Triggers seen before arming are deliberately ignored
            if (r_armed && triggered) begin
              r_trig_cnt <= r_trig_cnt + ONE_A;
            end else begin
              r_smpl_cnt <= w_smpl_inc;
              if (w_smpl_inc >= w_pre_req) begin
                r_armed <= 1'b1;
              end
            end
          end
        end
        ST_DONE: begin
          if (!capture_done) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
